// File: rtl/toubi_counter.sv
// Note acceptor: counts synchronized rising edges on the four denomination lines,
// accumulates against a latched price and hands change to the dispenser with a shift pulse.
module toubi_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] price,
  input  logic       qian1,
  input  logic       qian5,
  input  logic       qian10,
  input  logic       qian50,
  input  logic       confirm,
  input  logic       cancel,
  output logic [7:0] total,
  output logic       enough,
  output logic [7:0] change,
  output logic       shift,
  output logic       ovf,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAY     = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t        st;
  logic [7:0]    price_l;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    sync [SYNC_STAGES];
  logic [3:0]    prev;
  logic [3:0]    edges;
  logic [6:0]    sum;
  logic [8:0]    acc;
  logic          fits;
  logic [7:0]    total_upd;

  assign state = st;

  // Line order in every 4-bit vector: {qian50, qian10, qian5, qian1}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      prev <= '0;
    end else begin
      sync[0] <= {qian50, qian10, qian5, qian1};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    edges = sync[SYNC_STAGES-1] & ~prev;
    sum   = (edges[0] ? 7'd1  : 7'd0) + (edges[1] ? 7'd5  : 7'd0)
          + (edges[2] ? 7'd10 : 7'd0) + (edges[3] ? 7'd50 : 7'd0);
    acc       = {1'b0, total} + {2'b00, sum};
    fits      = ~acc[8];
    total_upd = fits ? acc[7:0] : total;
    enough    = (st == COLLECT) && (total >= price_l);
  end

  // Decisions use the pre-update enough; change is taken from the post-accumulate total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      total    <= '0;
      change   <= '0;
      price_l  <= '0;
      ovf      <= 1'b0;
      hold_cnt <= '0;
      shift    <= 1'b0;
    end else begin
      shift <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st      <= COLLECT;
            price_l <= price;
            total   <= '0;
            ovf     <= 1'b0;
            change  <= '0;
          end
        end
        COLLECT: begin
          total <= total_upd;
          if (!fits) ovf <= 1'b1;
          if (cancel) begin
            change <= total_upd;
            shift  <= 1'b1;
            st     <= PAY;
          end else if (confirm && enough) begin
            change <= total_upd - price_l;
            shift  <= 1'b1;
            st     <= PAY;
          end
        end
        PAY: begin
          hold_cnt <= HOLD_LOAD;
          st       <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            st    <= IDLE;
            total <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toubi_counter.sv
// Scoreboarded bench for toubi_counter: expected change values are queued per transaction
// and popped by a monitor on every shift pulse; totals come from a note-level model.
module tb_toubi_counter;

  logic       clk = 1'b0;
  logic       rst, start, qian1, qian5, qian10, qian50, confirm, cancel;
  logic [7:0] price;
  logic [7:0] total, change;
  logic       enough, shift, ovf;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int m_total, m_price;
  int m_ovf;

  toubi_counter #(.SYNC_STAGES(2), .HOLD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .start(start), .price(price),
    .qian1(qian1), .qian5(qian5), .qian10(qian10), .qian50(qian50),
    .confirm(confirm), .cancel(cancel), .total(total), .enough(enough),
    .change(change), .shift(shift), .ovf(ovf), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mask_value(input int m);
    return (m[0] ? 1 : 0) + (m[1] ? 5 : 0) + (m[2] ? 10 : 0) + (m[3] ? 50 : 0);
  endfunction

  // Monitor: each shift pulse must match exactly one queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (shift === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL shift_unexpected actual=1 expected=0 t=%0t", $time);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          check("change_at_shift", int'(change), int'(e));
          check("state_at_shift", int'(state), 2);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int p);
    price = 8'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_price = p;
    m_total = 0;
    m_ovf   = 0;
    @(negedge clk);
    check("start_state", int'(state), 1);
    check("start_total", int'(total), 0);
    check("start_ovf", int'(ovf), 0);
    check("start_change", int'(change), 0);
  endtask

  task automatic note(input int m);
    int s;
    qian1 = m[0]; qian5 = m[1]; qian10 = m[2]; qian50 = m[3];
    repeat (3) tick();
    qian1 = 1'b0; qian5 = 1'b0; qian10 = 1'b0; qian50 = 1'b0;
    repeat (3) tick();
    s = mask_value(m);
    if (m_total + s <= 255) m_total += s;
    else m_ovf = 1;
    @(negedge clk);
    check("note_total", int'(total), m_total);
    check("note_ovf", int'(ovf), m_ovf);
    check("note_enough", int'(enough), (m_total >= m_price) ? 1 : 0);
  endtask

  // action: 0 cancel, 1 confirm, 2 cancel+confirm together
  task automatic finish_txn(input int action);
    int e, h;
    bit done;
    if (action == 1 && m_total < m_price) begin
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      @(negedge clk);
      check("confirm_ignored_state", int'(state), 1);
      check("confirm_ignored_total", int'(total), m_total);
      action = 0;
    end
    e = (action == 1) ? (m_total - m_price) : m_total;
    exp_q.push_back(8'(e));
    cancel  = (action != 1);
    confirm = (action != 0);
    tick();
    cancel  = 1'b0;
    confirm = 1'b0;
    h = 0;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (state == 2'd3) h++;
      else if (state == 2'd0) done = 1'b1;
    end
    check("hold_reached_idle", int'(done), 1);
    check("hold_cycles", h, 32);
    check("idle_total", int'(total), 0);
    check("idle_change_kept", int'(change), e);
    check("idle_ovf_kept", int'(ovf), m_ovf);
    check("shift_consumed", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_total"}, int'(total), 0);
    check({tag, "_change"}, int'(change), 0);
    check({tag, "_shift"}, int'(shift), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_enough"}, int'(enough), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; price = '0; confirm = 1'b0; cancel = 1'b0;
    qian1 = 1'b0; qian5 = 1'b0; qian10 = 1'b0; qian50 = 1'b0;
    #12;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // price 30, one 50 note, confirm -> change 20
    do_start(30);
    note(4'b1000);
    finish_txn(1);

    // simultaneous 10+5, confirm ignored below price, then refund
    do_start(30);
    note(4'b0110);
    finish_txn(1);

    // overflow: sixth 50 rejected, ovf sticky until next start
    do_start(200);
    repeat (6) note(4'b1000);
    finish_txn(0);

    // cancel and confirm together -> full refund
    do_start(10);
    note(4'b0100);
    note(4'b0010);
    note(4'b0001);
    note(4'b0001);
    finish_txn(2);

    // line high across start is not counted
    qian1 = 1'b1;
    repeat (4) tick();
    do_start(10);
    repeat (6) tick();
    @(negedge clk);
    check("held_line_total", int'(total), 0);
    qian1 = 1'b0;
    repeat (3) tick();
    note(4'b0001);
    finish_txn(0);

    // async reset mid-collect; notes during reset lost
    do_start(100);
    note(4'b1000);
    note(4'b0100);
    note(4'b0010);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    qian5 = 1'b1;
    repeat (3) tick();
    qian5 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check_all_zero("postreset");

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      int p, nn;
      p = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      do_start(p);
      nn = $urandom_range(0, 7);
      for (int k = 0; k < nn; k++) note($urandom_range(1, 15));
      finish_txn($urandom_range(0, 2));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
